freemode_queue: RTL and testbench

- Parametrised successor to the single-note free-play mode. Key hits are captured with octave and length into a FIFO and played back in order by a player FSM, so notes entered faster than they sound are not lost.
- Each note drives a square-wave buzzer plus a one-hot note LED.
- Sits under the mode selector beside the playback/learn modes; the selector drives `en`.

---
 rtl/freemode_queue_pkg.sv | 29 ++
 rtl/freemode_queue_tone_gen.sv | 48 ++++
 rtl/freemode_queue.sv | 251 +++++++++++++++++++++++++
 tb/tb_freemode_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freemode_queue_pkg.sv
// Shared constants for the queued free-play mode: tone table, FSM states, width helper.
package freemode_queue_pkg;

  localparam int unsigned MAX_KEYS = 12;
  localparam int unsigned TW       = $clog2(MAX_KEYS);
  localparam int unsigned HALF_W   = 18;

  typedef logic [HALF_W-1:0] half_t;
  typedef half_t tone_tbl_t [MAX_KEYS];

  // Half-periods in clk cycles at octave 0 for a 100 MHz clock, C4..G5 diatonic.
  localparam tone_tbl_t TONE_HALF_DEFAULT = '{
    18'd191110, 18'd170265, 18'd151685, 18'd143172, 18'd127551, 18'd113636,
    18'd101239, 18'd95555,  18'd85131,  18'd75843,  18'd71586,  18'd63776
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/freemode_queue_tone_gen.sv
// Square-wave generator: toggles every `half` enabled cycles, cleared to low.
module tone_gen
  import freemode_queue_pkg::*;
#(
  parameter int unsigned W = HALF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] half,
  output logic         wave
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wave_q, wave_d;

  // Next-state: count enabled cycles, toggle and restart at half-1.
  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (clr) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (en) begin
      if (({1'b0, cnt_q} + 1'b1) >= {1'b0, half}) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  always_comb wave = wave_q;

endmodule

// File: rtl/freemode_queue.sv
// Queued free-play mode: captures key hits into a FIFO and plays them back in order.
module freemode_queue
  import freemode_queue_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 7,
  parameter int unsigned LEN_KEYS       = 4,
  parameter int unsigned NUM_OCTAVES    = 3,
  parameter int unsigned OCT_DEFAULT    = 1,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned LEN_UNIT_TICKS = 125,
  parameter int unsigned GAP_TICKS      = 20,
  parameter tone_tbl_t   TONE_HALF      = TONE_HALF_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            hit,
  input  logic                            oct_up,
  input  logic                            oct_down,
  input  logic [NUM_KEYS-1:0]             note_key,
  input  logic [LEN_KEYS-1:0]             length_key,
  output logic [NUM_KEYS-1:0]             led,
  output logic                            buzzer,
  output logic [idx_w(NUM_OCTAVES)-1:0]   octave,
  output logic                            playing,
  output logic [$clog2(DEPTH):0]          q_count,
  output logic                            overflow
);

  localparam int unsigned NW = idx_w(NUM_KEYS);
  localparam int unsigned OW = idx_w(NUM_OCTAVES);
  localparam int unsigned LW = $clog2(LEN_KEYS + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = idx_w(TICK_DIV);
  localparam int unsigned DW = $clog2(LEN_KEYS * LEN_UNIT_TICKS + 1);
  localparam int unsigned GW = idx_w(GAP_TICKS + 1);

  typedef struct packed {
    logic          rest;
    logic [NW-1:0] note;
    logic [OW-1:0] oct;
    logic [LW-1:0] len;
  } entry_t;

  logic          hit_prev_q, up_prev_q, dn_prev_q;
  logic          hit_ev, up_ev, dn_ev;
  logic [OW-1:0] oct_q, oct_d;
  logic          cap_valid_q, cap_valid_d;
  entry_t        cap_q, cap_d;
  logic [NW-1:0] note_idx;
  logic [LW-1:0] len_idx;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, push_ok, pop;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  state_e        state_q, state_d;
  entry_t        cur_q, cur_d;
  half_t         half_q, half_d;
  logic [DW-1:0] dur_q, dur_d, dur_tgt;
  logic [GW-1:0] gap_q, gap_d;
  logic          tone_clr, tone_en, tone_wave;

  // Edge events, octave update and capture of the key entry.
  always_comb begin
    hit_ev = hit & ~hit_prev_q;
    up_ev  = oct_up & ~up_prev_q;
    dn_ev  = oct_down & ~dn_prev_q;

    oct_d = oct_q;
    if (en && up_ev && !dn_ev && (oct_q != OW'(NUM_OCTAVES - 1))) begin
      oct_d = oct_q + 1'b1;
    end else if (en && dn_ev && !up_ev && (oct_q != '0)) begin
      oct_d = oct_q - 1'b1;
    end

    note_idx = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (note_key[i-1]) note_idx = NW'(i - 1);
    end
    len_idx = '0;
    for (int unsigned j = LEN_KEYS; j > 0; j--) begin
      if (length_key[j-1]) len_idx = LW'(j - 1);
    end

    cap_valid_d = en & hit_ev;
    cap_d       = cap_q;
    if (hit_ev) begin
      cap_d.rest = (note_key == '0);
      cap_d.note = note_idx;
      cap_d.oct  = oct_q;
      cap_d.len  = (length_key == '0) ? LW'(1) : (len_idx + 1'b1);
    end
  end

  // Free-running prescaler producing the timing tick.
  always_comb begin
    tick  = (pre_q == PW'(TICK_DIV - 1));
    pre_d = tick ? '0 : (pre_q + 1'b1);
  end

  // Player FSM: pop in IDLE, compute tone in LOAD, time note in PLAY, silence in GAP.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    half_d   = half_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    pop      = 1'b0;
    tone_clr = 1'b1;
    tone_en  = 1'b0;
    dur_tgt  = DW'(cur_q.len) * DW'(LEN_UNIT_TICKS);
    unique case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          cur_d   = mem_q[rd_q];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        half_d  = TONE_HALF[TW'(cur_q.note)] >> cur_q.oct;
        dur_d   = '0;
        gap_d   = '0;
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        tone_clr = 1'b0;
        tone_en  = ~cur_q.rest;
        if (tick) begin
          if ((dur_q + 1'b1) == dur_tgt) begin
            state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
            gap_d   = '0;
          end else begin
            dur_d = dur_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if ((gap_q + 1'b1) == GW'(GAP_TICKS)) state_d = ST_IDLE;
          else                                  gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      pop     = 1'b0;
    end
  end

  // FIFO bookkeeping; a push into a full queue is still taken when a pop frees a slot.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    full    = (cnt_q == (AW + 1)'(DEPTH));
    push_ok = cap_valid_q & (~full | pop);
    if (push_ok) begin
      mem_d[wr_q] = cap_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (cap_valid_q && !push_ok) ovf_d = 1'b1;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    if (!en) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  // FIFO storage needs no reset: occupancy is carried by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_prev_q  <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      oct_q       <= OW'(OCT_DEFAULT);
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      pre_q       <= '0;
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      half_q      <= '0;
      dur_q       <= '0;
      gap_q       <= '0;
    end else begin
      hit_prev_q  <= hit;
      up_prev_q   <= oct_up;
      dn_prev_q   <= oct_down;
      oct_q       <= oct_d;
      cap_valid_q <= cap_valid_d;
      cap_q       <= cap_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      pre_q       <= pre_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      half_q      <= half_d;
      dur_q       <= dur_d;
      gap_q       <= gap_d;
    end
  end

  tone_gen #(
    .W (HALF_W)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .clr  (tone_clr),
    .en   (tone_en),
    .half (half_q),
    .wave (tone_wave)
  );

  // Output decode from registered state.
  always_comb begin
    led      = '0;
    if ((state_q == ST_PLAY) && !cur_q.rest) led = NUM_KEYS'(1) << cur_q.note;
    buzzer   = tone_wave & (state_q == ST_PLAY) & ~cur_q.rest;
    octave   = oct_q;
    playing  = (state_q != ST_IDLE);
    q_count  = cnt_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_freemode_queue.sv
// Scoreboard bench for freemode_queue: stimulus queues expected notes, monitor checks playback.
module tb_freemode_queue;
  import freemode_queue_pkg::*;

  localparam int unsigned TD = 10;
  localparam tone_tbl_t TB_TONE = '{
    18'd40, 18'd60, 18'd36, 18'd44, 18'd52, 18'd28,
    18'd48, 18'd10, 18'd10, 18'd10, 18'd10, 18'd10
  };

  typedef struct {
    logic [6:0] led;
    int         half;
    int         ticks;
    bit         rest;
    bit         abrt;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b1, hit = 1'b0;
  logic       oct_up = 1'b0, oct_down = 1'b0;
  logic [6:0] note_key = '0;
  logic [3:0] length_key = '0;
  logic [6:0] led;
  logic       buzzer, playing, overflow;
  logic [1:0] octave;
  logic [2:0] q_count;

  int   n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  int   peak = 0;

  always #5 clk = ~clk;

  freemode_queue #(
    .NUM_KEYS       (7),
    .LEN_KEYS       (4),
    .NUM_OCTAVES    (3),
    .OCT_DEFAULT    (1),
    .DEPTH          (4),
    .TICK_DIV       (TD),
    .LEN_UNIT_TICKS (2),
    .GAP_TICKS      (1),
    .TONE_HALF      (TB_TONE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hit        (hit),
    .oct_up     (oct_up),
    .oct_down   (oct_down),
    .note_key   (note_key),
    .length_key (length_key),
    .led        (led),
    .buzzer     (buzzer),
    .octave     (octave),
    .playing    (playing),
    .q_count    (q_count),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_exp(input logic [6:0] l, input int half, input int ticks, input bit abrt);
    exp_t e;
    e.led = l; e.half = half; e.ticks = ticks; e.rest = (l == '0); e.abrt = abrt;
    exp_q.push_back(e);
  endtask

  task automatic press_hit(input logic [6:0] nk, input logic [3:0] lk);
    note_key = nk; length_key = lk; hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_oct(input bit up, input bit dn);
    oct_up = up; oct_down = dn;
    @(negedge clk); oct_up = 1'b0; oct_down = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      if (!playing && q_count == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_led(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (led != '0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk(name, ok, 1);
  endtask

  // Monitor: each playing burst is one note, compared against the next scoreboard entry.
  initial begin
    bit   in_note = 1'b0, have = 1'b0, prev_b = 1'b0;
    exp_t cur;
    int   p = 0, l = 0, run = 0, runbad = 0, ledbad = 0, ntog = 0, buz_on = 0;
    cur = '{led: '0, half: 0, ticks: 0, rest: 1'b0, abrt: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (int'(q_count) > peak) peak = int'(q_count);
        if (playing && !in_note) begin
          in_note = 1'b1;
          p = 0; l = 0; run = 0; runbad = 0; ledbad = 0; ntog = 0; buz_on = 0;
          if (exp_q.size() == 0) begin
            have = 1'b0;
            chk("unexpected_note", 1, 0);
          end else begin
            have = 1'b1;
            cur  = exp_q.pop_front();
          end
        end
        if (in_note && playing) begin
          p++;
          if (buzzer) buz_on++;
          if (led != '0) begin
            l++;
            if (led != cur.led) ledbad++;
            if (l == 1) begin
              run = 1; prev_b = buzzer;
            end else if (buzzer != prev_b) begin
              if (run != cur.half) runbad++;
              ntog++; run = 1; prev_b = buzzer;
            end else begin
              run++;
            end
          end
        end else if (in_note) begin
          in_note = 1'b0;
          if (have && cur.abrt) begin
            chk("abort_led_value", ledbad, 0);
          end else if (have && cur.rest) begin
            chk("rest_led_cycles", l, 0);
            chk("rest_buzzer_cycles", buz_on, 0);
            chk_rng("rest_len", p, (cur.ticks - 1) * TD + 12, cur.ticks * TD + 11);
          end else if (have) begin
            chk("note_led_value", ledbad, 0);
            chk_rng("note_len", l, (cur.ticks - 1) * TD + 1, cur.ticks * TD);
            chk_rng("note_gap", p - 1 - l, 1, TD);
            chk("tone_half_period", runbad, 0);
            chk("tone_toggles", ntog, (l - 1) / cur.half);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    logic [1:0] oct_save;
    repeat (2) @(negedge clk);
    chk("rst_octave", octave, 1);
    chk("rst_led", led, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_playing", playing, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    press_oct(1, 0);
    chk("oct_up_1", octave, 2);
    press_oct(1, 0);
    press_oct(1, 0);
    chk("oct_up_sat", octave, 2);
    press_oct(0, 1);
    chk("oct_down_1", octave, 1);
    press_oct(0, 1);
    press_oct(0, 1);
    chk("oct_down_sat", octave, 0);
    press_oct(1, 0);
    chk("oct_back_1", octave, 1);

    // Single note: note 0, len 3 -> 6 ticks, half 40>>1.
    push_exp(7'b0000001, 20, 6, 1'b0);
    note_key = 7'b0000001; length_key = 4'b0100; hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    @(negedge clk); chk("lat_qcount", q_count, 1);
    @(negedge clk); chk("lat_load_led", led, 0); chk("lat_load_playing", playing, 1);
    @(negedge clk); chk("lat_play_led", led, 7'b0000001);
    wait_idle("idle_single");

    // Overflow: long note then six hits; only four fit in the queue.
    push_exp(7'b1000000, 24, 8, 1'b0);
    press_hit(7'b1000000, 4'b1000);
    wait_led("wait_ovf_note");
    push_exp(7'b0000010, 30, 2, 1'b0);
    press_hit(7'b0000010, 4'b0001);
    push_exp(7'b0000100, 18, 2, 1'b0);
    press_hit(7'b0000100, 4'b0001);
    push_exp(7'b0001000, 22, 4, 1'b0);
    press_hit(7'b0001000, 4'b0010);
    push_exp(7'b0010000, 26, 2, 1'b0);
    press_hit(7'b0010000, 4'b0001);
    press_hit(7'b0100000, 4'b0001);
    press_hit(7'b0000001, 4'b0001);
    repeat (3) @(negedge clk);
    chk("ovf_qcount", q_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_peak", peak, 4);
    wait_idle("idle_ovf");

    // Rest entry, length_key 0001 -> 2 ticks.
    push_exp(7'b0000000, 1, 2, 1'b0);
    press_hit(7'b0000000, 4'b0001);
    wait_idle("idle_rest");

    // length_key 0 -> len 1 -> 2 ticks.
    push_exp(7'b0000100, 18, 2, 1'b0);
    press_hit(7'b0000100, 4'b0000);
    wait_idle("idle_len0");

    // en dropped mid-note with two entries queued.
    push_exp(7'b0001000, 22, 8, 1'b1);
    press_hit(7'b0001000, 4'b1000);
    wait_led("wait_abort_note");
    press_hit(7'b0010000, 4'b0001);
    press_hit(7'b0100000, 4'b0001);
    repeat (2) @(negedge clk);
    chk("abort_queued", q_count, 2);
    chk("abort_ovf_before", overflow, 1);
    oct_save = octave;
    en = 1'b0;
    @(negedge clk);
    chk("abort_buzzer", buzzer, 0);
    chk("abort_led", led, 0);
    chk("abort_qcount", q_count, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_playing", playing, 0);
    chk("abort_octave", octave, oct_save);
    press_hit(7'b0000001, 4'b0001);
    en = 1'b1;
    repeat (12) @(negedge clk);
    chk("dis_hit_qcount", q_count, 0);
    chk("dis_hit_playing", playing, 0);

    // Simultaneous up/down events leave the octave alone.
    press_oct(1, 1);
    chk("oct_both", octave, 1);

    repeat (5) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
